pipeline_hazard_ctrl: RTL and testbench



---
 rtl/pipeline_hazard_ctrl.sv | 111 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline.
// Drives the enable and flush inputs of the IF_ID, ID_EX, EX_MEM and MEM_WB latches
// and the PC write enable. It sequences dmem waits, load-use bubbles, control-flow
// flushes and the terminal halt. It also keeps a saturating count of stalled cycles.
//
// Ports:
//   CLK, nRST              clock, asynchronous active-low reset
//   ihit, dhit             imem / dmem access complete this cycle
//   mem_dREN, mem_dWEN     EX_MEM instruction accesses dmem
//   idex_MemRead, idex_rt  load in ID_EX and its destination register
//   ifid_rs, ifid_rt       source registers of the instruction in IF_ID
//   ex_redirect            EX supplies a PC correction
//   wb_halt                halt instruction reached MEM_WB
//   pc_en, *_en, *_flush   PC and pipeline latch controls (combinational)
//   halt                   registered sticky halt
//   stall_cnt              saturating count of edges with pc_en=0 outside HALT
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             idex_MemRead,
    input  logic [REG_W-1:0] idex_rt,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             ex_redirect,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {StRun, StDwait, StHalt} state_t;

    state_t state;
    logic   dreq;
    logic   load_use;
    logic   advance;

    assign dreq     = mem_dREN | mem_dWEN;
    assign load_use = idex_MemRead && (idex_rt != '0) &&
                      ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
    // While a dmem access is outstanding the whole pipe follows dhit; otherwise ihit.
    assign advance  = dreq ? dhit : ihit;

    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_en    = 1'b0;
        idex_flush = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        if (nRST && (state != StHalt) && advance) begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            if (ex_redirect) begin
                // Wrong-path work in IF_ID and ID_EX is discarded, including a
                // load-use victim; the PC takes the correction.
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                // Hold the dependent instruction in IF_ID, bubble into ID_EX.
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end else if (dreq && !ihit) begin
                // dmem finished but the fetch was displaced: bubble into IF_ID.
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= StRun;
            halt      <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if ((state != StHalt) && !pc_en && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (state != StHalt) begin
                if (wb_halt) begin
                    state <= StHalt;
                    halt  <= 1'b1;
                end else if (dreq && !dhit) begin
                    state <= StDwait;
                end else begin
                    state <= StRun;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 32;

    // Control vector order: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}
    localparam logic [6:0] CtlNone    = 7'b0000000;
    localparam logic [6:0] CtlNormal  = 7'b1101011;
    localparam logic [6:0] CtlLoadUse = 7'b0001111;
    localparam logic [6:0] CtlDisplc  = 7'b0111011;
    localparam logic [6:0] CtlRedir   = 7'b1111111;

    logic             CLK;
    logic             nRST;
    logic             ihit, dhit, mem_dREN, mem_dWEN, idex_MemRead, ex_redirect, wb_halt;
    logic [REG_W-1:0] idex_rt, ifid_rs, ifid_rt;

    logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halt;
    logic [CNT_W-1:0] stall_cnt;
    logic             pc_en_s, ifid_en_s, ifid_flush_s, idex_en_s, idex_flush_s;
    logic             exmem_en_s, memwb_en_s, halt_s;
    logic [3:0]       stall_cnt_s;
    logic [6:0]       ctl;

    int checks = 0;
    int errors = 0;

    assign ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en};

    pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN),
        .mem_dWEN(mem_dWEN), .idex_MemRead(idex_MemRead), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ex_redirect(ex_redirect), .wb_halt(wb_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_en(memwb_en), .halt(halt),
        .stall_cnt(stall_cnt)
    );

    // Narrow counter copy for the saturation check.
    pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(4)) dut_sat (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN),
        .mem_dWEN(mem_dWEN), .idex_MemRead(idex_MemRead), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ex_redirect(ex_redirect), .wb_halt(wb_halt),
        .pc_en(pc_en_s), .ifid_en(ifid_en_s), .ifid_flush(ifid_flush_s), .idex_en(idex_en_s),
        .idex_flush(idex_flush_s), .exmem_en(exmem_en_s), .memwb_en(memwb_en_s),
        .halt(halt_s), .stall_cnt(stall_cnt_s)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_idle();
        ihit = 1'b1; dhit = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0;
        idex_MemRead = 1'b0; idex_rt = '0; ifid_rs = '0; ifid_rt = '0;
        ex_redirect = 1'b0; wb_halt = 1'b0;
    endtask

    // Ends at posedge+1 with reset released and idle inputs applied.
    task automatic do_reset();
        @(posedge CLK);
        #1;
        nRST = 1'b0;
        set_idle();
        tick();
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge CLK);
        #1;
        set_idle();
        nRST = 1'b0;
        #1;
        checks++;
        if (ctl !== CtlNone) begin
            errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, CtlNone);
        end
        checks++;
        if (halt !== 1'b0) begin
            errors++; $display("FAIL reset_halt: got %b expected 0", halt);
        end
        checks++;
        if (stall_cnt !== '0) begin
            errors++; $display("FAIL reset_cnt: got %0d expected 0", stall_cnt);
        end
        tick();
        nRST = 1'b1;
    endtask

    task automatic test_run();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (ctl !== CtlNormal) begin
                errors++; $display("FAIL run_ctl[%0d]: got %b expected %b", i, ctl, CtlNormal);
            end
            tick();
        end
        checks++;
        if (halt !== 1'b0 || stall_cnt !== '0) begin
            errors++;
            $display("FAIL run_state: got halt=%b cnt=%0d expected halt=0 cnt=0", halt, stall_cnt);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        idex_MemRead = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8;
        #1;
        checks++;
        if (ctl !== CtlLoadUse) begin
            errors++; $display("FAIL lu_stall: got %b expected %b", ctl, CtlLoadUse);
        end
        tick();
        idex_MemRead = 1'b0; // bubble now in ID_EX
        #1;
        checks++;
        if (ctl !== CtlNormal) begin
            errors++; $display("FAIL lu_resume: got %b expected %b", ctl, CtlNormal);
        end
        tick();
        checks++;
        if (stall_cnt !== 32'd1) begin
            errors++; $display("FAIL lu_cnt: got %0d expected 1", stall_cnt);
        end
        // Destination $0 never creates a hazard.
        idex_MemRead = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
        #1;
        checks++;
        if (ctl !== CtlNormal) begin
            errors++; $display("FAIL lu_zero: got %b expected %b", ctl, CtlNormal);
        end
        tick();
        // Match on rt.
        idex_rt = 5'd9; ifid_rs = 5'd3; ifid_rt = 5'd9;
        #1;
        checks++;
        if (ctl !== CtlLoadUse) begin
            errors++; $display("FAIL lu_rt: got %b expected %b", ctl, CtlLoadUse);
        end
        tick();
        set_idle();
        #1;
        checks++;
        if (stall_cnt !== 32'd2) begin
            errors++; $display("FAIL lu_cnt2: got %0d expected 2", stall_cnt);
        end
    endtask

    task automatic test_dwait();
        do_reset();
        mem_dREN = 1'b1; dhit = 1'b0; ihit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ctl !== CtlNone) begin
                errors++; $display("FAIL dwait_ctl[%0d]: got %b expected %b", i, ctl, CtlNone);
            end
            tick();
        end
        dhit = 1'b1; ihit = 1'b0;
        #1;
        checks++;
        if (ctl !== CtlDisplc) begin
            errors++; $display("FAIL dwait_release: got %b expected %b", ctl, CtlDisplc);
        end
        tick();
        set_idle();
        #1;
        checks++;
        if (ctl !== CtlNormal || stall_cnt !== 32'd4) begin
            errors++;
            $display("FAIL dwait_after: got ctl=%b cnt=%0d expected ctl=%b cnt=4",
                     ctl, stall_cnt, CtlNormal);
        end
        // Store with simultaneous dhit and ihit advances normally.
        mem_dWEN = 1'b1; dhit = 1'b1;
        #1;
        checks++;
        if (ctl !== CtlNormal) begin
            errors++; $display("FAIL dwait_store_hit: got %b expected %b", ctl, CtlNormal);
        end
        tick();
    endtask

    task automatic test_redirect();
        do_reset();
        ex_redirect = 1'b1; idex_MemRead = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8;
        #1;
        checks++;
        if (ctl !== CtlRedir) begin
            errors++; $display("FAIL redir_lu: got %b expected %b", ctl, CtlRedir);
        end
        tick();
        set_idle();
        // Redirect held while dmem is busy, then applied on dhit.
        ex_redirect = 1'b1; mem_dREN = 1'b1; dhit = 1'b0;
        #1;
        checks++;
        if (ctl !== CtlNone) begin
            errors++; $display("FAIL redir_held: got %b expected %b", ctl, CtlNone);
        end
        tick();
        dhit = 1'b1;
        #1;
        checks++;
        if (ctl !== CtlRedir) begin
            errors++; $display("FAIL redir_release: got %b expected %b", ctl, CtlRedir);
        end
        tick();
        set_idle();
        #1;
        checks++;
        if (stall_cnt !== 32'd1) begin
            errors++; $display("FAIL redir_cnt: got %0d expected 1", stall_cnt);
        end
    endtask

    task automatic test_halt();
        do_reset();
        wb_halt = 1'b1;
        #1;
        checks++;
        if (halt !== 1'b0 || ctl !== CtlNormal) begin
            errors++; $display("FAIL halt_pre: got halt=%b ctl=%b expected halt=0 ctl=%b",
                               halt, ctl, CtlNormal);
        end
        tick();
        wb_halt = 1'b0;
        for (int i = 0; i < 20; i++) begin
            wb_halt = (i == 5); // ignored in HALT
            #1;
            checks++;
            if (halt !== 1'b1 || ctl !== CtlNone) begin
                errors++; $display("FAIL halt_hold[%0d]: got halt=%b ctl=%b expected halt=1 ctl=%b",
                                   i, halt, ctl, CtlNone);
            end
            tick();
        end
        checks++;
        if (stall_cnt !== '0) begin
            errors++; $display("FAIL halt_cnt: got %0d expected 0", stall_cnt);
        end
        #2;
        nRST = 1'b0;
        #1;
        checks++;
        if (halt !== 1'b0 || ctl !== CtlNone) begin
            errors++; $display("FAIL halt_reset: got halt=%b ctl=%b expected halt=0 ctl=%b",
                               halt, ctl, CtlNone);
        end
        tick();
        set_idle();
        nRST = 1'b1;
        #1;
        checks++;
        if (ctl !== CtlNormal || halt !== 1'b0) begin
            errors++; $display("FAIL halt_rerun: got halt=%b ctl=%b expected halt=0 ctl=%b",
                               halt, ctl, CtlNormal);
        end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        ihit = 1'b0;
        repeat (14) tick();
        checks++;
        if (stall_cnt_s !== 4'd14) begin
            errors++; $display("FAIL sat_14: got %0d expected 14", stall_cnt_s);
        end
        tick();
        checks++;
        if (stall_cnt_s !== 4'd15) begin
            errors++; $display("FAIL sat_15: got %0d expected 15", stall_cnt_s);
        end
        repeat (5) tick();
        checks++;
        if (stall_cnt_s !== 4'd15) begin
            errors++; $display("FAIL sat_hold: got %0d expected 15", stall_cnt_s);
        end
        checks++;
        if (stall_cnt !== 32'd20) begin
            errors++; $display("FAIL sat_wide: got %0d expected 20", stall_cnt);
        end
    endtask

    initial begin
        nRST = 1'b1;
        set_idle();
        test_reset();
        test_run();
        test_load_use();
        test_dwait();
        test_redirect();
        test_halt();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
